// File: rtl/alu_share_arb.sv
// Two-requester round-robin front end for a shared 16-bit ALU with a single
// registered response slot and per-requester saturating operation counters.

module alu_16 (
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y,
  output logic        z,
  output logic        v,
  output logic        n
);
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_SHL  = 3'd6;
  localparam logic [2:0] ALU_SHR  = 3'd7;

  // Result and signed-overflow flag for the selected operation
  always_comb begin
    y = 16'h0000;
    v = 1'b0;
    case (op)
      ALU_ADD: begin
        y = a + b;
        v = (a[15] == b[15]) && (y[15] != a[15]);
      end
      ALU_SUB: begin
        y = a - b;
        v = (a[15] != b[15]) && (y[15] != a[15]);
      end
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NAND: y = ~(a & b);
      ALU_SHL:  y = {a[14:0], 1'b0};
      ALU_SHR:  y = {1'b0, a[15:1]};
      default: begin
        y = 16'h0000;
        v = 1'b0;
      end
    endcase
    z = (y == 16'h0000);
    n = y[15];
  end
endmodule

module alu_share_arb #(
  parameter int CNT_W      = 16,
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [15:0]      rsp_out,
  output logic             rsp_z,
  output logic             rsp_v,
  output logic             rsp_n,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic [2:0]        op_hold_q, op_hold_d;
  logic [15:0]       a_hold_q, a_hold_d;
  logic [15:0]       b_hold_q, b_hold_d;
  logic              rsp_id_q, rsp_id_d;
  logic [15:0]       rsp_out_q, rsp_out_d;
  logic              rsp_z_q, rsp_z_d;
  logic              rsp_v_q, rsp_v_d;
  logic              rsp_n_q, rsp_n_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic              can_accept_s;
  logic              gnt_vld_s;
  logic              gnt_id_s;
  logic [2:0]        alu_op_s;
  logic [15:0]       alu_a_s;
  logic [15:0]       alu_b_s;
  logic [15:0]       alu_y_s;
  logic              alu_z_s;
  logic              alu_v_s;
  logic              alu_n_s;

  alu_16 u_alu (
    .op (alu_op_s),
    .a  (alu_a_s),
    .b  (alu_b_s),
    .y  (alu_y_s),
    .z  (alu_z_s),
    .v  (alu_v_s),
    .n  (alu_n_s)
  );

  // Grant selection and operand mux; ready is gated by rst_n so it reads 0 in reset
  always_comb begin
    can_accept_s = (state_q == EMPTY) || rsp_ready;
    gnt_vld_s    = 1'b0;
    gnt_id_s     = 1'b0;
    if (rst_n && can_accept_s) begin
      if (req0_valid && req1_valid) begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = prio_q;
      end else if (req0_valid) begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = 1'b0;
      end else if (req1_valid) begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = 1'b1;
      end else begin
        gnt_vld_s = 1'b0;
      end
    end else begin
      gnt_vld_s = 1'b0;
    end

    if (!gnt_vld_s) begin
      alu_op_s = op_hold_q;
      alu_a_s  = a_hold_q;
      alu_b_s  = b_hold_q;
    end else if (gnt_id_s) begin
      alu_op_s = req1_op;
      alu_a_s  = req1_a;
      alu_b_s  = req1_b;
    end else begin
      alu_op_s = req0_op;
      alu_a_s  = req0_a;
      alu_b_s  = req0_b;
    end
  end

  // Next-state for the slot FSM, response capture, priority and counters
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    op_hold_d = op_hold_q;
    a_hold_d  = a_hold_q;
    b_hold_d  = b_hold_q;
    rsp_id_d  = rsp_id_q;
    rsp_out_d = rsp_out_q;
    rsp_z_d   = rsp_z_q;
    rsp_v_d   = rsp_v_q;
    rsp_n_d   = rsp_n_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    if (gnt_vld_s) begin
      state_d   = FULL;
      prio_d    = ~gnt_id_s;
      op_hold_d = alu_op_s;
      a_hold_d  = alu_a_s;
      b_hold_d  = alu_b_s;
      rsp_id_d  = gnt_id_s;
      rsp_out_d = alu_y_s;
      rsp_z_d   = alu_z_s;
      rsp_v_d   = alu_v_s;
      rsp_n_d   = alu_n_s;
      if (!gnt_id_s && (cnt0_q != CNT_MAX)) begin
        cnt0_d = cnt0_q + CNT_W'(1);
      end else if (gnt_id_s && (cnt1_q != CNT_MAX)) begin
        cnt1_d = cnt1_q + CNT_W'(1);
      end else begin
        cnt0_d = cnt0_q;
      end
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // State and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      prio_q    <= RESET_PRIO;
      op_hold_q <= 3'd0;
      a_hold_q  <= 16'h0000;
      b_hold_q  <= 16'h0000;
      rsp_id_q  <= 1'b0;
      rsp_out_q <= 16'h0000;
      rsp_z_q   <= 1'b0;
      rsp_v_q   <= 1'b0;
      rsp_n_q   <= 1'b0;
      cnt0_q    <= {CNT_W{1'b0}};
      cnt1_q    <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      op_hold_q <= op_hold_d;
      a_hold_q  <= a_hold_d;
      b_hold_q  <= b_hold_d;
      rsp_id_q  <= rsp_id_d;
      rsp_out_q <= rsp_out_d;
      rsp_z_q   <= rsp_z_d;
      rsp_v_q   <= rsp_v_d;
      rsp_n_q   <= rsp_n_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  assign req0_ready = gnt_vld_s & ~gnt_id_s;
  assign req1_ready = gnt_vld_s & gnt_id_s;
  assign rsp_valid  = (state_q == FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_out    = rsp_out_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_v      = rsp_v_q;
  assign rsp_n      = rsp_n_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: table of operations with hand-computed results,
// a cycle model of grant/slot/counters and a scoreboard queue of responses.

module tb_alu_share_arb;
  localparam int CNT_W = 3;
  localparam int CMAX  = 7;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_SHR  = 3'd7;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic        z;
    logic        v;
    logic        n;
  } vec_t;

  typedef struct {
    logic        id;
    logic [15:0] y;
    logic        z;
    logic        v;
    logic        n;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic req0_ready, req1_ready;
  logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
  logic [15:0] req0_a = 16'h0, req0_b = 16'h0, req1_a = 16'h0, req1_b = 16'h0;
  logic rsp_valid, rsp_id, rsp_z, rsp_v, rsp_n;
  logic [15:0] rsp_out;
  logic [CNT_W-1:0] cnt0, cnt1;

  vec_t tbl [12];
  rsp_t sb_q [$];
  rsp_t last_r;
  bit   m_full;
  bit   m_prio;
  int   m_cnt0, m_cnt1;
  int   checks = 0;
  int   errors = 0;

  alu_share_arb #(.CNT_W(CNT_W), .RESET_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_z(rsp_z), .rsp_v(rsp_v), .rsp_n(rsp_n),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_prio = 1'b0;
    m_cnt0 = 0;
    m_cnt1 = 0;
    sb_q.delete();
    last_r = '{id: 1'b0, y: 16'h0000, z: 1'b0, v: 1'b0, n: 1'b0};
  endtask

  // Reset values are visible immediately, and ready stays low even with valids high
  task automatic check_in_reset(input string tag);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_cnt0"}, {29'd0, cnt0}, 32'd0);
    chk({tag, "_cnt1"}, {29'd0, cnt1}, 32'd0);
    chk({tag, "_ready0"}, {31'd0, req0_ready}, 32'd0);
    chk({tag, "_ready1"}, {31'd0, req1_ready}, 32'd0);
    chk({tag, "_rsp_out"}, {16'd0, rsp_out}, 32'd0);
    chk({tag, "_rsp_flags"}, {28'd0, rsp_id, rsp_z, rsp_v, rsp_n}, 32'd0);
  endtask

  // One clock cycle: entered at posedge+1, drives inputs, checks at negedge, returns at next posedge+1
  task automatic step(input bit v0, input int i0, input bit v1, input int i1, input bit rr);
    bit   can, g0, g1;
    rsp_t r;
    req0_valid = v0; req0_op = tbl[i0].op; req0_a = tbl[i0].a; req0_b = tbl[i0].b;
    req1_valid = v1; req1_op = tbl[i1].op; req1_a = tbl[i1].a; req1_b = tbl[i1].b;
    rsp_ready  = rr;
    @(negedge clk);
    can = !m_full || rr;
    g0  = can && v0 && (!v1 || (m_prio == 1'b0));
    g1  = can && v1 && (!v0 || (m_prio == 1'b1));
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_full});
    chk("cnt0", {29'd0, cnt0}, 32'(m_cnt0));
    chk("cnt1", {29'd0, cnt1}, 32'(m_cnt1));
    if (m_full && sb_q.size() > 0) begin
      r = sb_q[0];
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, r.id});
      chk("rsp_out", {16'd0, rsp_out}, {16'd0, r.y});
      chk("rsp_zvn", {29'd0, rsp_z, rsp_v, rsp_n}, {29'd0, r.z, r.v, r.n});
      if (rr) begin
        last_r = r;
        void'(sb_q.pop_front());
      end
    end else if (m_full) begin
      chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
    end else begin
      chk("hold_id", {31'd0, rsp_id}, {31'd0, last_r.id});
      chk("hold_out", {16'd0, rsp_out}, {16'd0, last_r.y});
      chk("hold_zvn", {29'd0, rsp_z, rsp_v, rsp_n}, {29'd0, last_r.z, last_r.v, last_r.n});
    end
    if (g0) begin
      sb_q.push_back('{id: 1'b0, y: tbl[i0].y, z: tbl[i0].z, v: tbl[i0].v, n: tbl[i0].n});
      if (m_cnt0 < CMAX) m_cnt0++;
      m_prio = 1'b1;
    end
    if (g1) begin
      sb_q.push_back('{id: 1'b1, y: tbl[i1].y, z: tbl[i1].z, v: tbl[i1].v, n: tbl[i1].n});
      if (m_cnt1 < CMAX) m_cnt1++;
      m_prio = 1'b0;
    end
    if (g0 || g1) m_full = 1'b1;
    else if (rr) m_full = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{op: OP_NAND, a: 16'h0003, b: 16'h0005, y: 16'hFFFE, z: 1'b0, v: 1'b0, n: 1'b1};
    tbl[1]  = '{op: OP_NAND, a: 16'hFFFF, b: 16'hFFFF, y: 16'h0000, z: 1'b1, v: 1'b0, n: 1'b0};
    tbl[2]  = '{op: OP_ADD,  a: 16'h7FFF, b: 16'h0001, y: 16'h8000, z: 1'b0, v: 1'b1, n: 1'b1};
    tbl[3]  = '{op: OP_ADD,  a: 16'h0001, b: 16'h0002, y: 16'h0003, z: 1'b0, v: 1'b0, n: 1'b0};
    tbl[4]  = '{op: OP_SUB,  a: 16'h8000, b: 16'h0001, y: 16'h7FFF, z: 1'b0, v: 1'b1, n: 1'b0};
    tbl[5]  = '{op: OP_SUB,  a: 16'h0005, b: 16'h0005, y: 16'h0000, z: 1'b1, v: 1'b0, n: 1'b0};
    tbl[6]  = '{op: OP_AND,  a: 16'hF0F0, b: 16'hFF00, y: 16'hF000, z: 1'b0, v: 1'b0, n: 1'b1};
    tbl[7]  = '{op: OP_OR,   a: 16'h0F00, b: 16'h00F0, y: 16'h0FF0, z: 1'b0, v: 1'b0, n: 1'b0};
    tbl[8]  = '{op: OP_XOR,  a: 16'hAAAA, b: 16'hFFFF, y: 16'h5555, z: 1'b0, v: 1'b0, n: 1'b0};
    tbl[9]  = '{op: OP_SHL,  a: 16'h8001, b: 16'h1234, y: 16'h0002, z: 1'b0, v: 1'b0, n: 1'b0};
    tbl[10] = '{op: OP_SHR,  a: 16'h8001, b: 16'h1234, y: 16'h4000, z: 1'b0, v: 1'b0, n: 1'b0};
    tbl[11] = '{op: OP_ADD,  a: 16'hFFFF, b: 16'h0001, y: 16'h0000, z: 1'b1, v: 1'b0, n: 1'b0};

    model_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_in_reset("por");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single NAND on port 0, then port 1 NAND refilling the slot as it drains
    step(1'b1, 0, 1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1, 1, 1'b1);
    step(1'b0, 0, 1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0, 0, 1'b1);

    // Both valid with the consumer always ready: grants alternate 0,1,0,1
    step(1'b1, 2, 1'b1, 4, 1'b1);
    step(1'b1, 3, 1'b1, 4, 1'b1);
    step(1'b1, 3, 1'b1, 5, 1'b1);
    step(1'b1, 6, 1'b1, 5, 1'b1);
    step(1'b1, 6, 1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0, 0, 1'b1);

    // Consumer stalls for three cycles with both requesters waiting
    step(1'b1, 7, 1'b1, 8, 1'b1);
    step(1'b0, 7, 1'b1, 8, 1'b0);
    step(1'b1, 9, 1'b1, 8, 1'b0);
    step(1'b1, 9, 1'b1, 8, 1'b0);
    step(1'b1, 9, 1'b1, 8, 1'b0);
    step(1'b1, 9, 1'b1, 8, 1'b1);
    step(1'b1, 9, 1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0, 0, 1'b1);

    // Table sweep over every opcode, alternating ports
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) step(1'b1, i, 1'b0, 0, 1'b1);
      else            step(1'b0, 0, 1'b1, i, 1'b1);
    end
    step(1'b0, 0, 1'b0, 0, 1'b1);

    // Asynchronous reset while FULL with requests pending
    step(1'b1, 10, 1'b0, 0, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_in_reset("midrst");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 2, 1'b1, 3, 1'b1);
    step(1'b0, 0, 1'b1, 3, 1'b1);

    // Nine more port-0 transfers drive cnt0 into saturation
    for (int k = 0; k < 9; k++) step(1'b1, k, 1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0, 0, 1'b1);
    chk("cnt0_sat", {29'd0, cnt0}, 32'd7);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 16-bit ALU (ALU_16). Instantiated inside this block.
- Requesters are the execute stage (port 0) and the address/branch unit (port 1). Each presents op/a/b with valid/ready.
- The block grants one request per cycle, drives the ALU, and registers result plus z/v/n flags into a single response slot tagged with the requester id.
- Sits between the issue logic and the ALU, and keeps per-requester saturating operation counters for performance debug.

Parameters:
CNT_W, 16, width of each per-requester accepted-operation counter (saturating)
RESET_PRIO, 0, requester id that holds priority after reset (0 or 1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle (valid&ready = transfer)
req0_op  input  3  ALU opcode (codes from the shared ALU definitions, e.g. `ALU_NAND)
req0_a  input  16  operand A
req0_b  input  16  operand B
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 accepted this cycle
req1_op  input  3  ALU opcode
req1_a  input  16  operand A
req1_b  input  16  operand B
rsp_valid  output  1  response slot full
rsp_ready  input  1  consumer takes response this cycle
rsp_id  output  1  requester that issued the held result
rsp_out  output  16  registered ALU result
rsp_z  output  1  registered zero flag
rsp_v  output  1  registered overflow flag
rsp_n  output  1  registered sign flag
cnt0  output  CNT_W  operations accepted from requester 0, saturates at all-ones
cnt1  output  CNT_W  operations accepted from requester 1, saturates at all-ones

Behaviour:
- Reset (rst_n low, asynchronous): rsp_valid=0, rsp_id=0, rsp_out=0, rsp_z/v/n=0, cnt0=cnt1=0, priority pointer=RESET_PRIO, state=EMPTY. req*_ready is combinational and reads 0 while in reset.
- State machine: EMPTY (slot free) and FULL (slot holds an unconsumed result).
- can_accept = (state==EMPTY) | rsp_ready. The slot drains and refills in the same cycle, so sustained throughput is one operation per cycle.
- Grant (combinational):
  - If can_accept and exactly one valid is high, grant that requester.
  - If both are valid, grant the requester named by the priority pointer.
  - reqX_ready = grant to X; at most one ready is high per cycle.
  - No ready is asserted without the corresponding valid.
- ALU operand mux: the granted requester's op/a/b drive the ALU. When nothing is granted, hold the last granted inputs; there is no functional effect.
- On a grant at edge T:
  - rsp_out/z/v/n capture the ALU outputs for that request; rsp_id takes the granted id; state goes FULL.
  - rsp_valid=1 from T+1. Latency is 1 cycle, accept to rsp_valid.
- Priority pointer: after any grant, the pointer moves to the non-granted requester. It is unchanged on cycles with no grant. With both valid continuously, grants alternate 0,1,0,1...
- FULL with rsp_ready=0: no grant; all outputs hold stable. Requesters must hold valid and payload until ready.
- FULL with rsp_ready=1 and no valid request: state goes EMPTY; rsp_valid=0 next cycle; rsp data holds its last value.
- FULL with rsp_ready=1 and a valid request: consume and refill in the same edge; rsp_valid stays 1 and the new data appears next cycle.
- EMPTY with rsp_ready high: no effect.
- Counters: cntX increments by 1 on each accepted transfer of requester X. It holds at 2^CNT_W-1 and never wraps.
- Flags are exactly as produced by the ALU for the captured operation; this block does not reinterpret them.
- Reset asserted mid-operation discards the held result and clears the counters. The first grant after reset release follows RESET_PRIO.

Test Plan:
- Reset, then a single request on req0: op=`ALU_NAND, a=0x0003, b=0x0005 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_out=0xFFFE, n=1, z=0, v=0; cnt0=1.
- req1 NAND a=b=0xFFFF with rsp_ready=1 -> rsp_out=0x0000, z=1, n=0, v=0, rsp_id=1; rsp_valid drops the cycle after consumption.
- Both valid for 4 cycles with rsp_ready=1 and RESET_PRIO=0 -> grants 0,1,0,1; back-to-back rsp_valid with no bubble; cnt0=2, cnt1=2.
- rsp_ready=0 for 3 cycles after a result with both requesters valid -> no readys asserted; rsp_out/id/flags stable; accept resumes on the cycle rsp_ready rises.
- Reset pulsed while FULL with a pending request -> rsp_valid=0 and counters=0 immediately (asynchronous); first grant after release goes to RESET_PRIO.
- CNT_W=3 with 9 requester-0 transfers -> cnt0 saturates at 7 and stays 7.
